// File: rtl/micro_op_sequencer.sv
// Micro-op sequencer between the IF/ID latch and decode control: splits CALL/RET/RTI into
// two sub-ops and injects the two-part interrupt sequence at an instruction boundary.
module micro_op_sequencer #(
  parameter int             OPW     = 5,
  parameter logic [OPW-1:0] NOP_OP  = 5'b00000,
  parameter logic [OPW-1:0] IRQ_OP1 = 5'b11110,
  parameter logic [OPW-1:0] IRQ_OP2 = 5'b11111
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           instr_valid_i,
  input  logic [OPW-1:0] opcode_in_i,
  output logic           in_ready_o,
  input  logic           stall_i,
  input  logic           flush_i,
  input  logic           interrupt_i,
  output logic [OPW-1:0] op_out_o,
  output logic           op_valid_o,
  output logic           irq_ack_o,
  output logic           illegal_op_o,
  output logic           busy_o
);

  // state  | meaning
  // RUN    | pass-through, instruction boundary
  // SECOND | issue saved second half of a macro-op
  // IRQ2   | issue IRQ_OP2 (atomic, flush ignored)
  typedef enum logic [1:0] {RUN, SECOND, IRQ2} state_e;

  localparam logic [OPW-1:0] CALL1 = 5'b11000;
  localparam logic [OPW-1:0] CALL2 = 5'b11001;
  localparam logic [OPW-1:0] RET1  = 5'b11010;
  localparam logic [OPW-1:0] RET2  = 5'b11011;
  localparam logic [OPW-1:0] RTI1  = 5'b11100;
  localparam logic [OPW-1:0] RTI2  = 5'b11101;

  state_e         state_q, state_d;
  logic [OPW-1:0] op_q, op_d;
  logic [OPW-1:0] saved_q, saved_d;
  logic           valid_q, valid_d;
  logic           ack_q, ack_d;
  logic           illegal_q, illegal_d;
  logic           pend_q, pend_d;
  logic           prev_q, prev_d;
  logic           irq_clear;

  assign in_ready_o   = (state_q == RUN) & ~pend_q & ~stall_i & ~flush_i;
  assign busy_o       = (state_q != RUN);
  assign op_out_o     = op_q;
  assign op_valid_o   = valid_q;
  assign irq_ack_o    = ack_q;
  assign illegal_op_o = illegal_q;

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    valid_d   = valid_q;
    saved_d   = saved_q;
    ack_d     = 1'b0;
    illegal_d = 1'b0;
    irq_clear = 1'b0;
    prev_d    = interrupt_i;

    if (flush_i && state_q != IRQ2) begin
      op_d    = NOP_OP;
      valid_d = 1'b0;
      state_d = RUN;
      saved_d = NOP_OP;
    end else if (!stall_i) begin
      unique case (state_q)
        RUN: begin
          if (pend_q) begin
            op_d      = IRQ_OP1;
            valid_d   = 1'b1;
            ack_d     = 1'b1;
            irq_clear = 1'b1;
            state_d   = IRQ2;
          end else if (instr_valid_i) begin
            op_d    = opcode_in_i;
            valid_d = 1'b1;
            unique case (opcode_in_i)
              CALL1: begin saved_d = CALL2; state_d = SECOND; end
              RET1:  begin saved_d = RET2;  state_d = SECOND; end
              RTI1:  begin saved_d = RTI2;  state_d = SECOND; end
              CALL2, RET2, RTI2, IRQ_OP1, IRQ_OP2: begin
                op_d      = NOP_OP;
                valid_d   = 1'b0;
                illegal_d = 1'b1;
              end
              default: ;
            endcase
          end else begin
            op_d    = NOP_OP;
            valid_d = 1'b0;
          end
        end
        SECOND: begin
          op_d    = saved_q;
          valid_d = 1'b1;
          state_d = RUN;
        end
        IRQ2: begin
          op_d    = IRQ_OP2;
          valid_d = 1'b1;
          state_d = RUN;
        end
        default: state_d = RUN;
      endcase
    end

    // A new rising edge wins over a same-cycle clear.
    pend_d = (interrupt_i & ~prev_q) | (pend_q & ~irq_clear);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= RUN;
      op_q      <= NOP_OP;
      valid_q   <= 1'b0;
      saved_q   <= NOP_OP;
      ack_q     <= 1'b0;
      illegal_q <= 1'b0;
      pend_q    <= 1'b0;
      prev_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      valid_q   <= valid_d;
      saved_q   <= saved_d;
      ack_q     <= ack_d;
      illegal_q <= illegal_d;
      pend_q    <= pend_d;
      prev_q    <= prev_d;
    end
  end

endmodule

// File: tb/tb_micro_op_sequencer.sv
// Directed bench for micro_op_sequencer: macro-op expansion, interrupt injection,
// stall/flush handling, illegal input and asynchronous reset.
module tb_micro_op_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       instr_valid;
  logic [4:0] opcode_in;
  logic       in_ready;
  logic       stall;
  logic       flush;
  logic       interrupt;
  logic [4:0] op_out;
  logic       op_valid;
  logic       irq_ack;
  logic       illegal_op;
  logic       busy;

  int n_vec = 0;
  int n_err = 0;

  micro_op_sequencer dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .instr_valid_i(instr_valid),
    .opcode_in_i  (opcode_in),
    .in_ready_o   (in_ready),
    .stall_i      (stall),
    .flush_i      (flush),
    .interrupt_i  (interrupt),
    .op_out_o     (op_out),
    .op_valid_o   (op_valid),
    .irq_ack_o    (irq_ack),
    .illegal_op_o (illegal_op),
    .busy_o       (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; instr_valid = 1'b0; opcode_in = 5'b0;
    stall = 1'b0; flush = 1'b0; interrupt = 1'b0;
    #12;
    n_vec++;
    if (op_out !== 5'b00000 || op_valid !== 1'b0 || irq_ack !== 1'b0 ||
        illegal_op !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset: op=%b v=%b ack=%b ill=%b busy=%b, want 00000 0 0 0 0",
               op_out, op_valid, irq_ack, illegal_op, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_back_to_back();
    instr_valid = 1'b1; opcode_in = 5'b01001;
    #1;
    n_vec++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_rdy0: in_ready=%b want 1", in_ready); end
    step();
    n_vec++;
    if (op_out !== 5'b01001 || op_valid !== 1'b1) begin
      n_err++; $display("FAIL b2b_add: op=%b v=%b want 01001 1", op_out, op_valid);
    end
    opcode_in = 5'b01010;
    #1;
    n_vec++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_rdy1: in_ready=%b want 1", in_ready); end
    step();
    n_vec++;
    if (op_out !== 5'b01010 || op_valid !== 1'b1) begin
      n_err++; $display("FAIL b2b_sub: op=%b v=%b want 01010 1", op_out, op_valid);
    end
    instr_valid = 1'b0;
    step();
    n_vec++;
    if (op_out !== 5'b00000 || op_valid !== 1'b0) begin
      n_err++; $display("FAIL b2b_idle: op=%b v=%b want 00000 0", op_out, op_valid);
    end
  endtask

  task automatic test_call();
    instr_valid = 1'b1; opcode_in = 5'b11000;
    step();
    instr_valid = 1'b0;
    #1;
    n_vec++;
    if (op_out !== 5'b11000 || op_valid !== 1'b1 || busy !== 1'b1 || in_ready !== 1'b0) begin
      n_err++; $display("FAIL call1: op=%b v=%b busy=%b rdy=%b want 11000 1 1 0",
                        op_out, op_valid, busy, in_ready);
    end
    step();
    n_vec++;
    if (op_out !== 5'b11001 || op_valid !== 1'b1 || busy !== 1'b0) begin
      n_err++; $display("FAIL call2: op=%b v=%b busy=%b want 11001 1 0", op_out, op_valid, busy);
    end
  endtask

  task automatic test_irq_mid_call();
    instr_valid = 1'b1; opcode_in = 5'b11000; interrupt = 1'b1;
    step();
    n_vec++;
    if (op_out !== 5'b11000 || irq_ack !== 1'b0) begin
      n_err++; $display("FAIL irq_c1: op=%b ack=%b want 11000 0", op_out, irq_ack);
    end
    opcode_in = 5'b01001;
    step();
    n_vec++;
    if (op_out !== 5'b11001 || in_ready !== 1'b0) begin
      n_err++; $display("FAIL irq_c2: op=%b rdy=%b want 11001 0", op_out, in_ready);
    end
    step();
    n_vec++;
    if (op_out !== 5'b11110 || op_valid !== 1'b1 || irq_ack !== 1'b1 || busy !== 1'b1) begin
      n_err++; $display("FAIL irq_op1: op=%b v=%b ack=%b busy=%b want 11110 1 1 1",
                        op_out, op_valid, irq_ack, busy);
    end
    step();
    n_vec++;
    if (op_out !== 5'b11111 || op_valid !== 1'b1 || irq_ack !== 1'b0 || in_ready !== 1'b1) begin
      n_err++; $display("FAIL irq_op2: op=%b v=%b ack=%b rdy=%b want 11111 1 0 1",
                        op_out, op_valid, irq_ack, in_ready);
    end
    step();
    n_vec++;
    if (op_out !== 5'b01001 || op_valid !== 1'b1 || irq_ack !== 1'b0) begin
      n_err++; $display("FAIL irq_next: op=%b v=%b ack=%b want 01001 1 0", op_out, op_valid, irq_ack);
    end
    instr_valid = 1'b0; interrupt = 1'b0;
    step();
  endtask

  task automatic test_stall();
    instr_valid = 1'b1; opcode_in = 5'b11010;
    step();
    instr_valid = 1'b0; stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_vec++;
      if (op_out !== 5'b11010 || op_valid !== 1'b1 || busy !== 1'b1) begin
        n_err++; $display("FAIL stall_hold%0d: op=%b v=%b busy=%b want 11010 1 1",
                          i, op_out, op_valid, busy);
      end
    end
    stall = 1'b0;
    step();
    n_vec++;
    if (op_out !== 5'b11011 || op_valid !== 1'b1 || busy !== 1'b0) begin
      n_err++; $display("FAIL stall_rel: op=%b v=%b busy=%b want 11011 1 0", op_out, op_valid, busy);
    end
  endtask

  task automatic test_flush();
    instr_valid = 1'b1; opcode_in = 5'b11100;
    step();
    instr_valid = 1'b0; flush = 1'b1;
    step();
    n_vec++;
    if (op_out !== 5'b00000 || op_valid !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL flush_sec: op=%b v=%b busy=%b want 00000 0 0", op_out, op_valid, busy);
    end
    flush = 1'b0;
    step();
    n_vec++;
    if (op_out !== 5'b00000 || op_valid !== 1'b0) begin
      n_err++; $display("FAIL flush_no_rti2: op=%b v=%b want 00000 0", op_out, op_valid);
    end
    interrupt = 1'b1;
    step();
    step();
    n_vec++;
    if (op_out !== 5'b11110 || irq_ack !== 1'b1) begin
      n_err++; $display("FAIL flush_irq1: op=%b ack=%b want 11110 1", op_out, irq_ack);
    end
    flush = 1'b1;
    step();
    n_vec++;
    if (op_out !== 5'b11111 || op_valid !== 1'b1 || busy !== 1'b0) begin
      n_err++; $display("FAIL flush_irq2: op=%b v=%b busy=%b want 11111 1 0", op_out, op_valid, busy);
    end
    flush = 1'b0; interrupt = 1'b0;
    step();
  endtask

  task automatic test_illegal();
    instr_valid = 1'b1; opcode_in = 5'b11111;
    step();
    n_vec++;
    if (op_out !== 5'b00000 || op_valid !== 1'b0 || illegal_op !== 1'b1) begin
      n_err++; $display("FAIL illegal: op=%b v=%b ill=%b want 00000 0 1", op_out, op_valid, illegal_op);
    end
    opcode_in = 5'b11001;
    step();
    n_vec++;
    if (op_out !== 5'b00000 || op_valid !== 1'b0 || illegal_op !== 1'b1 || busy !== 1'b0) begin
      n_err++; $display("FAIL illegal_c2: op=%b v=%b ill=%b busy=%b want 00000 0 1 0",
                        op_out, op_valid, illegal_op, busy);
    end
    instr_valid = 1'b0;
    step();
    n_vec++;
    if (illegal_op !== 1'b0) begin
      n_err++; $display("FAIL illegal_pulse: ill=%b want 0", illegal_op);
    end
  endtask

  task automatic test_reset_mid_irq();
    interrupt = 1'b1;
    step();
    step();
    n_vec++;
    if (op_out !== 5'b11110 || busy !== 1'b1) begin
      n_err++; $display("FAIL rst_pre: op=%b busy=%b want 11110 1", op_out, busy);
    end
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if (op_out !== 5'b00000 || op_valid !== 1'b0 || irq_ack !== 1'b0 ||
        illegal_op !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL rst_async: op=%b v=%b ack=%b ill=%b busy=%b want 00000 0 0 0 0",
                        op_out, op_valid, irq_ack, illegal_op, busy);
    end
    interrupt = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    n_vec++;
    if (op_out !== 5'b00000 || op_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_err++; $display("FAIL rst_after: op=%b v=%b rdy=%b want 00000 0 1", op_out, op_valid, in_ready);
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_call();
    test_irq_mid_call();
    test_stall();
    test_flush();
    test_illegal();
    test_reset_mid_irq();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
